// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Two-master AXI read-channel arbiter. The dcache (s0) and the icache (s1)
// share one AXI read port toward memory. Only one read burst is outstanding
// at a time: a master is granted in IDLE, its AR request is forwarded in
// ADDR, and the R beats are routed back to it in DATA. The beat count is
// checked against the accepted burst length, and beat_err pulses for one
// cycle on a mismatch.
//
// Parameters
//   FIXED_PRIO  0: round-robin (the master not granted last wins a tie)
//               1: fixed priority, s0 always wins a tie
//
// Ports
//   aclk, aresetn                clock, asynchronous active-low reset
//   s0_ar*  / s0_arready         dcache AR request / accept
//   s0_r*   / s0_rready          dcache R data / accept
//   s1_ar*  / s1_arready         icache AR request / accept
//   s1_r*   / s1_rready          icache R data / accept
//   m_ar*   / m_arready          AR request toward memory / accept
//   m_r*    / m_rready           R data from memory / accept
//   busy                         high whenever a burst is in progress
//   beat_err                     one-cycle pulse on a burst-length mismatch
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic [31:0] s0_araddr,
    input  logic [7:0]  s0_arlen,
    input  logic [2:0]  s0_arsize,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [31:0] s0_rdata,
    output logic        s0_rlast,
    output logic        s0_rvalid,
    input  logic        s0_rready,

    input  logic [31:0] s1_araddr,
    input  logic [7:0]  s1_arlen,
    input  logic [2:0]  s1_arsize,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [31:0] s1_rdata,
    output logic        s1_rlast,
    output logic        s1_rvalid,
    input  logic        s1_rready,

    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,

    output logic        busy,
    output logic        beat_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    // grant / last_grant encode the master: 0 = s0, 1 = s1
    logic       grant;
    logic       last_grant;
    logic       pick;
    logic       any_req;
    logic       ar_hs;
    logic       r_hs;
    logic       len_match;
    logic       err_now;
    logic [7:0] arlen_q;
    logic [7:0] beat_cnt;
    logic       beat_err_q;

    assign any_req = s0_arvalid | s1_arvalid;

    // Arbitration decision, only consumed while IDLE. On a round-robin tie
    // the master that was not served last wins; last_grant resets to s1 so
    // s0 takes the very first tie.
    always_comb begin
        pick = 1'b0;
        if (s0_arvalid && s1_arvalid) begin
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (s1_arvalid) begin
            pick = 1'b1;
        end
    end

    // m_arvalid is constantly high in ADDR, so m_arready alone completes
    // the address handshake there.
    assign ar_hs     = (state == ADDR) && m_arready;
    assign r_hs      = (state == DATA) && m_rvalid && m_rready;
    assign len_match = (beat_cnt == arlen_q);

    // A beat is wrong if rlast arrives before/after the beat numbered arlen,
    // or if the beat numbered arlen arrives without rlast.
    assign err_now   = r_hs && (m_rlast ? !len_match : len_match);

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (any_req)         state_next = ADDR;
            ADDR: if (ar_hs)           state_next = DATA;
            DATA: if (r_hs && m_rlast) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Burst bookkeeping: grant is frozen for the whole burst, last_grant is
    // only updated once the address has actually been accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            arlen_q    <= 8'd0;
            beat_cnt   <= 8'd0;
            beat_err_q <= 1'b0;
        end else begin
            beat_err_q <= err_now;
            if (state == IDLE && any_req) begin
                grant <= pick;
            end
            if (ar_hs) begin
                arlen_q    <= m_arlen;
                beat_cnt   <= 8'd0;
                last_grant <= grant;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

    // Output logic. The AR payload is a live pass-through of the granted
    // master, so whatever it presents is what memory sees; m_arvalid does
    // not follow the master's arvalid, so a request cannot be withdrawn.
    always_comb begin
        m_arvalid  = 1'b0;
        m_araddr   = 32'd0;
        m_arlen    = 8'd0;
        m_arsize   = 3'd0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_rready   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        unique case (state)
            ADDR: begin
                m_arvalid = 1'b1;
                if (grant) begin
                    m_araddr   = s1_araddr;
                    m_arlen    = s1_arlen;
                    m_arsize   = s1_arsize;
                    s1_arready = m_arready;
                end else begin
                    m_araddr   = s0_araddr;
                    m_arlen    = s0_arlen;
                    m_arsize   = s0_arsize;
                    s0_arready = m_arready;
                end
            end
            DATA: begin
                if (grant) begin
                    m_rready  = s1_rready;
                    s1_rvalid = m_rvalid;
                end else begin
                    m_rready  = s0_rready;
                    s0_rvalid = m_rvalid;
                end
            end
            default: begin
            end
        endcase
    end

    // Data and last are broadcast; rvalid alone selects the recipient.
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rlast = m_rlast;
    assign s1_rlast = m_rlast;

    assign busy     = (state != IDLE);
    assign beat_err = beat_err_q;

endmodule
